// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: register tags, hazard
// FSM states, the canonical NOP encoding and the x0 tag.
package pipe_ctrl_pkg;

   typedef logic [5:0] reg_tag_t;

   typedef enum logic {
      RUN      = 1'b0,
      FPU_WAIT = 1'b1
   } hz_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam reg_tag_t    TAG_X0   = 6'h00;

   // A source read in ID depends on the EX destination; integer x0 never does.
   function automatic logic tag_hit(reg_tag_t rd, reg_tag_t rs, logic used);
      return used && (rd == rs) && (rd != TAG_X0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: hazard inputs from ID/EX and the
// enable/flush controls back to the pipeline registers. The performance
// counters exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
   import pipe_ctrl_pkg::*;

   reg_tag_t rs1_ID;
   reg_tag_t rs2_ID;
   logic     rs1_used_ID;
   logic     rs2_used_ID;
   reg_tag_t rd_EX;
   logic     mem_read_EX;
   logic     branch_taken_EX;
   logic     fpu_multi_EX;

   logic     pc_en;
   logic     if_id_en;
   logic     id_ex_en;
   logic     if_id_flush;
   logic     id_ex_flush;
   logic     ex_mem_flush;
   logic     fpu_start;
   logic     fpu_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
             mem_read_EX, branch_taken_EX, fpu_multi_EX,
      input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, fpu_start, fpu_busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
             mem_read_EX, branch_taken_EX, fpu_multi_EX,
      output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, fpu_start, fpu_busy, stall_cnt, flush_cnt
   );
`else
   modport master (
      output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
             mem_read_EX, branch_taken_EX, fpu_multi_EX,
      input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, fpu_start, fpu_busy
   );

   modport slave (
      input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX,
             mem_read_EX, branch_taken_EX, fpu_multi_EX,
      output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, fpu_start, fpu_busy
   );
`endif

endinterface

// File: rtl/hazard_ctrl_lat_timer.sv
// Loadable down-counter with a zero flag. Loading presets FPU_LAT-2 so the
// flag rises in the last cycle the FPU op must stay in EX.
module lat_timer #(
   parameter int FPU_LAT = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int W = $clog2(FPU_LAT);

   logic [W-1:0] cnt;

   // Count register: load wins over decrement, decrement stops at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(FPU_LAT - 2);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RISC-V + FPU pipeline.
// Resolves load-use stalls and taken-branch flushes with zero-cycle response,
// and holds the pipeline while a multi-cycle FPU op (FDIV/FSQRT) sits in EX.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal flow; load-use / branch / FPU entry decoded from inputs
//   FPU_WAIT | FPU op held in EX; stall until the latency timer hits zero
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FPU_LAT = 12
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);

   hz_state_e state;
   logic      tmr_load;
   logic      tmr_dec;
   logic      tmr_zero;
   logic      load_use;

   logic pc_en, if_id_en, id_ex_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush;
   logic fpu_start, fpu_busy;

   assign load_use = bus.mem_read_EX &&
                     (tag_hit(bus.rd_EX, bus.rs1_ID, bus.rs1_used_ID) ||
                      tag_hit(bus.rd_EX, bus.rs2_ID, bus.rs2_used_ID));

   assign tmr_load = (state == RUN) && bus.fpu_multi_EX;
   assign tmr_dec  = (state == FPU_WAIT);

   lat_timer #(.FPU_LAT(FPU_LAT)) u_lat_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .dec  (tmr_dec),
      .zero (tmr_zero)
   );

   // State register: enter FPU_WAIT on an FPU op, leave when the timer expires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:      if (bus.fpu_multi_EX) state <= FPU_WAIT;
            FPU_WAIT: if (tmr_zero)         state <= RUN;
            default:  state <= RUN;
         endcase
      end
   end

   // Pipeline controls decoded from state and current hazard inputs.
   // Reset forces the RUN defaults so an abandoned FPU op releases at once.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      fpu_start    = 1'b0;
      fpu_busy     = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (bus.fpu_multi_EX) begin
                  fpu_start    = 1'b1;
                  fpu_busy     = 1'b1;
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
               end else if (bus.branch_taken_EX) begin
                  if_id_flush  = 1'b1;
                  id_ex_flush  = 1'b1;
               end else if (load_use) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_flush  = 1'b1;
               end
            end
            FPU_WAIT: begin
               fpu_busy = 1'b1;
               if (!tmr_zero) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_flush  = id_ex_flush;
   assign bus.ex_mem_flush = ex_mem_flush;
   assign bus.fpu_start    = fpu_start;
   assign bus.fpu_busy     = fpu_busy;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating counters of stalled cycles and front-end flush cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (!pc_en && (stall_cnt_r != 32'hFFFF_FFFF))
            stall_cnt_r <= stall_cnt_r + 32'd1;
         if ((if_id_flush || id_ex_flush) && (flush_cnt_r != 32'hFFFF_FFFF))
            flush_cnt_r <= flush_cnt_r + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_r;
   assign bus.flush_cnt = flush_cnt_r;
`endif

   // EX is occupied by the FPU op while waiting, so no load or branch can be there.
   a_no_branch_in_wait: assert property (@(posedge clk) disable iff (!rst)
      (state == FPU_WAIT) |-> !bus.branch_taken_EX);

   a_no_load_in_wait: assert property (@(posedge clk) disable iff (!rst)
      (state == FPU_WAIT) |-> !bus.mem_read_EX);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FPU_LAT=8: a vector table for the
// combinational RUN decode, then hand sequences for FPU stall timing, reset
// during FPU_WAIT and (with HAZARD_PERF_EN) the performance counters.
module tb_hazard_ctrl;

   // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, fpu_start, fpu_busy}
   localparam logic [7:0] DEF  = 8'b1110_0000;
   localparam logic [7:0] LU   = 8'b0010_1000;
   localparam logic [7:0] BR   = 8'b1111_1000;
   localparam logic [7:0] FPU0 = 8'b0000_0111;
   localparam logic [7:0] FPUW = 8'b0000_0101;
   localparam logic [7:0] FPUR = 8'b1110_0001;

   typedef struct {
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic       u1;
      logic       u2;
      logic [5:0] rd;
      logic       mr;
      logic       bt;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[11];

   always #5 clk = ~clk;

   hazard_ctrl_if u_if ();

   hazard_ctrl #(.FPU_LAT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   function automatic logic [7:0] outs();
      return {u_if.pc_en, u_if.if_id_en, u_if.id_ex_en, u_if.if_id_flush,
              u_if.id_ex_flush, u_if.ex_mem_flush, u_if.fpu_start, u_if.fpu_busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      u_if.rs1_ID          = 6'h00;
      u_if.rs2_ID          = 6'h00;
      u_if.rs1_used_ID     = 1'b0;
      u_if.rs2_used_ID     = 1'b0;
      u_if.rd_EX           = 6'h00;
      u_if.mem_read_EX     = 1'b0;
      u_if.branch_taken_EX = 1'b0;
      u_if.fpu_multi_EX    = 1'b0;
   endtask

   // Full FDIV-style sequence: op in EX for cycles k=0..7, next instruction at k=8.
   task automatic fpu_seq(input string tag);
      logic [7:0] e;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         u_if.fpu_multi_EX = (k <= 7);
         #1;
         if (k == 0)      e = FPU0;
         else if (k < 7)  e = FPUW;
         else if (k == 7) e = FPUR;
         else             e = DEF;
         chk($sformatf("%s_k%0d", tag, k), 32'(outs()), 32'(e));
      end
      @(negedge clk);
      u_if.fpu_multi_EX = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{6'h00, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, DEF};
      vecs[1]  = '{6'h05, 6'h00, 1'b1, 1'b0, 6'h05, 1'b1, 1'b0, LU};
      vecs[2]  = '{6'h00, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, DEF};
      vecs[3]  = '{6'h01, 6'h20, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, LU};
      vecs[4]  = '{6'h05, 6'h00, 1'b0, 1'b0, 6'h05, 1'b1, 1'b0, DEF};
      vecs[5]  = '{6'h03, 6'h07, 1'b1, 1'b0, 6'h07, 1'b1, 1'b0, DEF};
      vecs[6]  = '{6'h05, 6'h00, 1'b1, 1'b0, 6'h05, 1'b1, 1'b1, BR};
      vecs[7]  = '{6'h00, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, BR};
      vecs[8]  = '{6'h05, 6'h00, 1'b1, 1'b0, 6'h05, 1'b0, 1'b0, DEF};
      vecs[9]  = '{6'h05, 6'h00, 1'b1, 1'b0, 6'h25, 1'b1, 1'b0, DEF};
      vecs[10] = '{6'h0A, 6'h0A, 1'b1, 1'b1, 6'h0A, 1'b1, 1'b0, LU};

      idle_inputs();
      #2;
      chk("reset_outputs", 32'(outs()), 32'(DEF));
`ifdef HAZARD_PERF_EN
      chk("reset_stall_cnt", u_if.stall_cnt, 32'd0);
      chk("reset_flush_cnt", u_if.flush_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // Combinational RUN decode table.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         u_if.rs1_ID          = vecs[i].rs1;
         u_if.rs2_ID          = vecs[i].rs2;
         u_if.rs1_used_ID     = vecs[i].u1;
         u_if.rs2_used_ID     = vecs[i].u2;
         u_if.rd_EX           = vecs[i].rd;
         u_if.mem_read_EX     = vecs[i].mr;
         u_if.branch_taken_EX = vecs[i].bt;
         #1;
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // Load-use stall for one cycle, then the bubble reaches EX.
      @(negedge clk);
      idle_inputs();
      u_if.mem_read_EX = 1'b1;
      u_if.rd_EX       = 6'h05;
      u_if.rs1_ID      = 6'h05;
      u_if.rs1_used_ID = 1'b1;
      #1;
      chk("lu_stall", 32'(outs()), 32'(LU));
      @(negedge clk);
      u_if.mem_read_EX = 1'b0;
      u_if.rd_EX       = 6'h00;
      #1;
      chk("lu_release", 32'(outs()), 32'(DEF));

      // Clean counters, then a full FPU sequence.
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      fpu_seq("fpu1");
`ifdef HAZARD_PERF_EN
      chk("perf_stall_cnt", u_if.stall_cnt, 32'd7);
      chk("perf_flush_cnt", u_if.flush_cnt, 32'd0);
`endif

      // Reset at the third FPU_WAIT cycle abandons the op.
      for (int k = 0; k <= 2; k++) begin
         @(negedge clk);
         u_if.fpu_multi_EX = 1'b1;
         #1;
         chk($sformatf("rstseq_k%0d", k), 32'(outs()), 32'(k == 0 ? FPU0 : FPUW));
      end
      @(negedge clk);
      rst = 1'b0;
      u_if.fpu_multi_EX = 1'b0;
      #1;
      chk("rst_mid_wait", 32'(outs()), 32'(DEF));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("after_rst_release", 32'(outs()), 32'(DEF));
      fpu_seq("fpu2");
`ifdef HAZARD_PERF_EN
      chk("perf2_stall_cnt", u_if.stall_cnt, 32'd7);

      // Saturation of the stall counter.
      @(negedge clk);
      force dut.stall_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_r;
      u_if.mem_read_EX = 1'b1;
      u_if.rd_EX       = 6'h05;
      u_if.rs1_ID      = 6'h05;
      u_if.rs1_used_ID = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_cnt_sat", u_if.stall_cnt, 32'hFFFF_FFFF);
      idle_inputs();
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V + FPU core. It drives the enable and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register. It resolves load-use hazards and taken-branch redirects. It also holds the pipeline for a fixed number of cycles while a multi-cycle FPU operation (FDIV/FSQRT) occupies EX.

## Interface
- FPU_LAT, 12: cycles a multi-cycle FPU op needs in EX (legal ≥ 2).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rs1_ID, rs2_ID  in  6  source tags in ID: {is_fp, addr[4:0]}.
- rs1_used_ID, rs2_used_ID  in  1  the corresponding source is actually read.
- rd_EX  in  6  destination tag of the instruction in EX.
- mem_read_EX  in  1  the instruction in EX is a load (LW/FLW).
- branch_taken_EX  in  1  a branch/jump in EX redirects the PC.
- fpu_multi_EX  in  1  the instruction in EX is a multi-cycle FPU op.
- pc_en  out  1  PC register update enable.
- if_id_en, id_ex_en  out  1  pipeline register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  inject a NOP (0x00000013) / bubble.
- fpu_start  out  1  one-cycle start pulse to the FPU.
- fpu_busy  out  1  a multi-cycle FPU op is in progress.
- stall_cnt, flush_cnt  out  32  performance counters (only with HAZARD_PERF_EN).

## Operation
- FSM states: RUN and FPU_WAIT. The latency counter `cnt` is $clog2(FPU_LAT) bits wide.
- Default outputs in RUN with no event: pc_en, if_id_en and id_ex_en are 1. All flushes, fpu_start and fpu_busy are 0.
- Load-use hazard (RUN) fires when all of the following hold:
  - mem_read_EX is 1.
  - rd_EX ≠ 6'h00 (integer x0 is never a hazard; FP f0, tag 6'h20, is a hazard).
  - rd_EX equals rs1_ID with rs1_used_ID set, or rd_EX equals rs2_ID with rs2_used_ID set.
- Load-use response: pc_en=0, if_id_en=0, id_ex_flush=1. This lasts one cycle only.
- Taken branch (RUN): if_id_flush=1, id_ex_flush=1, pc_en=1. A taken branch has priority over a load-use hazard in the same cycle.
- Multi-cycle FPU op (RUN, fpu_multi_EX=1), same cycle:
  - fpu_start=1 and fpu_busy=1.
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1.
  - Load cnt←FPU_LAT-2; next state is FPU_WAIT.
- FPU_WAIT:
  - fpu_busy=1.
  - While cnt≠0: same stall outputs as the entry cycle; cnt decrements.
  - When cnt==0: all enables are 1 and ex_mem_flush=0, so the FPU op advances to MEM; next state is RUN.
- Inputs that cannot occur in FPU_WAIT (EX holds the FPU op): branch_taken_EX and mem_read_EX are ignored there. Each has an assertion.
- Reset, including mid-FPU_WAIT: state←RUN, cnt←0, and outputs immediately take the RUN defaults. An FPU op interrupted by reset is abandoned.

## Timing
- Everything except the state and cnt registers is combinational from the current inputs. There is zero-cycle response to hazards.
- A multi-cycle op entering EX at cycle T:
  - fpu_start is high at T only.
  - fpu_busy is high for cycles T..T+FPU_LAT-1.
  - The enables are low for cycles T..T+FPU_LAT-2, i.e. FPU_LAT-1 stall cycles.
  - The op moves to MEM at the clock edge ending cycle T+FPU_LAT-1.
- There is no retrigger: after release, EX holds the next instruction.
- Back-to-back FPU ops: re-entry to FPU_WAIT is legal in the first RUN cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments in every cycle where pc_en=0.
  - flush_cnt increments in every cycle where if_id_flush or id_ex_flush is 1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- HAZARD_PERF_EN undefined: the counters and their ports are absent. Behaviour is otherwise identical.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the `reg_tag_t` typedef (6-bit);
  - the `hz_state_e` enum {RUN, FPU_WAIT};
  - the constants NOP_INST=32'h00000013 and TAG_X0=6'h00.
- One sub-module, `lat_timer`: a loadable down-counter with a zero flag, parameterised by FPU_LAT.

## Test plan
- mem_read_EX=1, rd_EX=6'h05, rs1_ID=6'h05, rs1_used_ID=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1.
- rd_EX=6'h00 matching rs1_ID -> no stall. rd_EX=6'h20 matching rs2_ID=6'h20 with rs2_used_ID=1 -> stall. rd_EX matching an unused source -> no stall.
- Load-use and branch_taken_EX in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1.
- FPU_LAT=8, fpu_multi_EX at T -> fpu_start at T only; fpu_busy for 8 cycles; enables low for 7 cycles; ex_mem_flush for 7 cycles; RUN at T+8.
- rst low at the third FPU_WAIT cycle -> immediate RUN defaults. After release, a new fpu_multi_EX gives a full FPU_LAT sequence.
- With HAZARD_PERF_EN: the above sequence -> stall_cnt=7 and flush_cnt=0. Preloading stall_cnt to the maximum by force, then stalling -> stays at 32'hFFFFFFFF.
